// File: rtl/iq_window_pkg.sv
// Shared defaults and sample type for the IQ sliding-window block.
// Optional FLUSH input is enabled with the IQ_WINDOW_FLUSH_EN macro.
package iq_window_pkg;

    localparam int DEF_SAMPLE_BITS = 2;
    localparam int DEF_WINDOW_LEN  = 33;
    localparam int DEF_WIN_W       = DEF_SAMPLE_BITS * DEF_WINDOW_LEN;

    typedef struct packed {
        logic [DEF_SAMPLE_BITS-1:0] i;
        logic [DEF_SAMPLE_BITS-1:0] q;
    } iq_sample_t;

endpackage

// File: rtl/iq_window_shiftreg_fill_sat_counter.sv
// Saturating fill counter: counts writes up to MAX, never wraps.
// A clear restarts the count, and a same-cycle increment leaves it at one.
module fill_sat_counter #(
    parameter int CNT_W = 6,
    parameter int MAX   = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    assign at_max = (count == CNT_W'(MAX));

    // count register: reset, clear-then-load, or saturating increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iq_window_shiftreg.sv
// Sliding-window IQ deinterleaver with fill tracking and a snapshot register.
// Define IQ_WINDOW_FLUSH_EN to add the FLUSH input (clears window and fill).
module iq_window_shiftreg
    import iq_window_pkg::*;
#(
    parameter  int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter  int WINDOW_LEN  = DEF_WINDOW_LEN,
    localparam int CNT_W       = $clog2(WINDOW_LEN + 1),
    localparam int WIN_W       = SAMPLE_BITS * WINDOW_LEN
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     WE,
    input  logic [2*SAMPLE_BITS-1:0] WDATA,
    input  logic                     SNAP_REQ,
`ifdef IQ_WINDOW_FLUSH_EN
    input  logic                     FLUSH,
`endif
    output logic [WIN_W-1:0]         RDATA_I,
    output logic [WIN_W-1:0]         RDATA_Q,
    output logic                     FULL,
    output logic [CNT_W-1:0]         FILL,
    output logic [WIN_W-1:0]         SNAP_I,
    output logic [WIN_W-1:0]         SNAP_Q,
    output logic                     SNAP_VLD,
    output logic                     SNAP_PART
);

    logic                   flush;
    logic [SAMPLE_BITS-1:0] wd_i;
    logic [SAMPLE_BITS-1:0] wd_q;
    logic [SAMPLE_BITS-1:0] win_i [WINDOW_LEN];
    logic [SAMPLE_BITS-1:0] win_q [WINDOW_LEN];

`ifdef IQ_WINDOW_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign wd_i = WDATA[2*SAMPLE_BITS-1:SAMPLE_BITS];
    assign wd_q = WDATA[SAMPLE_BITS-1:0];

    // window lanes: index 0 holds the newest sample
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int k = 0; k < WINDOW_LEN; k++) begin
                win_i[k] <= '0;
                win_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < WINDOW_LEN; k++) begin
                win_i[k] <= '0;
                win_q[k] <= '0;
            end
            if (WE) begin
                win_i[0] <= wd_i;
                win_q[0] <= wd_q;
            end
        end else if (WE) begin
            win_i[0] <= wd_i;
            win_q[0] <= wd_q;
            for (int k = 1; k < WINDOW_LEN; k++) begin
                win_i[k] <= win_i[k-1];
                win_q[k] <= win_q[k-1];
            end
        end
    end

    for (genvar g = 0; g < WINDOW_LEN; g++) begin : g_map
        assign RDATA_I[(WINDOW_LEN-1-g)*SAMPLE_BITS +: SAMPLE_BITS] = win_i[g];
        assign RDATA_Q[(WINDOW_LEN-1-g)*SAMPLE_BITS +: SAMPLE_BITS] = win_q[g];
    end

    fill_sat_counter #(
        .CNT_W (CNT_W),
        .MAX   (WINDOW_LEN)
    ) u_fill (
        .clk    (CLK),
        .rst_n  (RST_N),
        .inc    (WE),
        .clr    (flush),
        .count  (FILL),
        .at_max (FULL)
    );

    // snapshot: capture the pre-shift window and flag partial fills
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            SNAP_I    <= '0;
            SNAP_Q    <= '0;
            SNAP_VLD  <= 1'b0;
            SNAP_PART <= 1'b0;
        end else begin
            SNAP_VLD <= SNAP_REQ;
            if (SNAP_REQ) begin
                SNAP_I    <= RDATA_I;
                SNAP_Q    <= RDATA_Q;
                SNAP_PART <= ~FULL;
            end
        end
    end

endmodule

// File: tb/tb_iq_window_shiftreg.sv
// Bench for iq_window_shiftreg: vector table, directed corners, random vs model.
// Flush checks are compiled in when IQ_WINDOW_FLUSH_EN is defined.
module tb_iq_window_shiftreg;

    localparam int SB = 2;
    localparam int WL = 33;
    localparam int W  = SB * WL;
    localparam int CW = 6;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          WE;
    logic [3:0]    WDATA;
    logic          SNAP_REQ;
`ifdef IQ_WINDOW_FLUSH_EN
    logic          FLUSH;
`endif
    logic [W-1:0]  RDATA_I, RDATA_Q, SNAP_I, SNAP_Q;
    logic          FULL, SNAP_VLD, SNAP_PART;
    logic [CW-1:0] FILL;

    always #5 CLK = ~CLK;

    iq_window_shiftreg dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WE        (WE),
        .WDATA     (WDATA),
        .SNAP_REQ  (SNAP_REQ),
`ifdef IQ_WINDOW_FLUSH_EN
        .FLUSH     (FLUSH),
`endif
        .RDATA_I   (RDATA_I),
        .RDATA_Q   (RDATA_Q),
        .FULL      (FULL),
        .FILL      (FILL),
        .SNAP_I    (SNAP_I),
        .SNAP_Q    (SNAP_Q),
        .SNAP_VLD  (SNAP_VLD),
        .SNAP_PART (SNAP_PART)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: queue of samples, newest at index 0
    logic [3:0]   mq[$];
    logic [W-1:0] m_si = '0, m_sq = '0;
    logic         m_vld = 1'b0, m_part = 1'b0;

    function automatic logic [W-1:0] m_win(bit is_q);
        logic [W-1:0] r;
        r = '0;
        for (int n = 1; n <= mq.size(); n++) begin
            r[(WL-n)*SB +: SB] = is_q ? mq[n-1][1:0] : mq[n-1][3:2];
        end
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(bit rst, bit we, logic [3:0] wd, bit snap, bit fl);
        if (!rst) begin
            mq.delete();
            m_si = '0; m_sq = '0; m_vld = 1'b0; m_part = 1'b0;
        end else begin
            if (snap) begin
                m_si   = m_win(0);
                m_sq   = m_win(1);
                m_part = (mq.size() != WL);
            end
            m_vld = snap;
            if (fl) mq.delete();
            if (we) begin
                mq.push_front(wd);
                if (mq.size() > WL) void'(mq.pop_back());
            end
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".rdata_i"},   RDATA_I,   m_win(0));
        chk({tag, ".rdata_q"},   RDATA_Q,   m_win(1));
        chk({tag, ".fill"},      FILL,      mq.size());
        chk({tag, ".full"},      FULL,      mq.size() == WL);
        chk({tag, ".snap_i"},    SNAP_I,    m_si);
        chk({tag, ".snap_q"},    SNAP_Q,    m_sq);
        chk({tag, ".snap_vld"},  SNAP_VLD,  m_vld);
        chk({tag, ".snap_part"}, SNAP_PART, m_part);
    endtask

    task automatic step(string tag, bit rst, bit we, logic [3:0] wd, bit snap, bit fl);
        RST_N    = rst;
        WE       = we;
        WDATA    = wd;
        SNAP_REQ = snap;
`ifdef IQ_WINDOW_FLUSH_EN
        FLUSH    = fl;
`endif
        model_edge(rst, we, wd, snap, fl);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit         rst;
        bit         we;
        bit         snap;
        logic [3:0] wd;
        int         fill;
        bit         full;
        bit         vld;
        bit         part;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [3:0]   w4;
        logic [W-1:0] exp_v;
        tbl[0] = '{0, 1, 1, 4'hF, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 4'h9, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 1, 4'h6, 2, 0, 1, 1};
        tbl[3] = '{1, 0, 0, 4'h3, 2, 0, 0, 1};
        tbl[4] = '{1, 0, 1, 4'h3, 2, 0, 1, 1};
        tbl[5] = '{1, 1, 1, 4'hC, 3, 0, 1, 1};
        tbl[6] = '{0, 1, 0, 4'h5, 0, 0, 0, 0};

        RST_N = 1'b0; WE = 1'b0; WDATA = '0; SNAP_REQ = 1'b0;
`ifdef IQ_WINDOW_FLUSH_EN
        FLUSH = 1'b0;
`endif
        @(posedge CLK);
        #1;

        for (int v = 0; v < 7; v++) begin
            step("tbl", tbl[v].rst, tbl[v].we, tbl[v].wd, tbl[v].snap, 1'b0);
            chk("tbl.fill_k", FILL, tbl[v].fill);
            chk("tbl.full_k", FULL, tbl[v].full);
            chk("tbl.vld_k",  SNAP_VLD, tbl[v].vld);
            chk("tbl.part_k", SNAP_PART, tbl[v].part);
        end
        chk("rst.rdata_i_zero", RDATA_I, '0);

        step("fill.rst", 0, 0, 4'h0, 0, 0);
        for (int n = 1; n <= 33; n++) begin
            w4 = 4'(n);
            step("fill", 1, 1, w4, 0, 0);
            if (n == 32) chk("fill.not_full_32", FULL, 1'b0);
        end
        chk("fill.full_33", FULL, 1'b1);
        chk("fill.fill_33", FILL, 6'd33);
        chk("fill.msb_i",   RDATA_I[65:64], 2'b00);
        chk("fill.lsb_q",   RDATA_Q[1:0], 2'b01);
        for (int n = 34; n <= 40; n++) begin
            w4 = 4'(n);
            step("sat", 1, 1, w4, 0, 0);
        end
        chk("sat.fill", FILL, 6'd33);
        chk("sat.lsb_i", RDATA_I[1:0], 2'b10);
        chk("sat.lsb_q", RDATA_Q[1:0], 2'b00);
        chk("sat.msb_i", RDATA_I[65:64], 2'b10);

        step("snap.rst", 0, 0, 4'h0, 0, 0);
        for (int n = 1; n <= 10; n++) begin
            w4 = 4'(n + 3);
            step("snap.w", 1, 1, w4, 0, 0);
        end
        exp_v = m_win(0);
        step("snap.we", 1, 1, 4'hA, 1, 0);
        chk("snap.i_pre", SNAP_I, exp_v);
        chk("snap.vld1", SNAP_VLD, 1'b1);
        chk("snap.part1", SNAP_PART, 1'b1);
        step("snap.idle", 1, 0, 4'h0, 0, 0);
        chk("snap.vld0", SNAP_VLD, 1'b0);
        for (int n = 0; n < 25; n++) begin
            w4 = 4'($urandom_range(0, 15));
            step("snap.f", 1, 1, w4, 0, 0);
        end
        step("snap.b2b1", 1, 1, 4'h7, 1, 0);
        step("snap.b2b2", 1, 0, 4'h0, 1, 0);
        chk("snap.vld_b2b", SNAP_VLD, 1'b1);
        chk("snap.part0", SNAP_PART, 1'b0);

        for (int n = 1; n <= 5; n++) begin
            step("mid.rst", n == 1 ? 0 : 1, 1, 4'(n), 0, 0);
        end
        step("mid.rst", 0, 1, 4'hE, 1, 0);
        chk("mid.fill0", FILL, 6'd0);
        chk("mid.win0", RDATA_Q, '0);
        step("mid.w", 1, 1, 4'h5, 0, 0);
        chk("mid.fill1", FILL, 6'd1);

`ifdef IQ_WINDOW_FLUSH_EN
        for (int n = 0; n < 33; n++) begin
            w4 = 4'($urandom_range(1, 15));
            step("fl.f", 1, 1, w4, 0, 0);
        end
        step("fl.snap", 1, 0, 4'h0, 1, 0);
        exp_v = m_si;
        step("fl.we", 1, 1, 4'hF, 0, 1);
        chk("fl.fill1", FILL, 6'd1);
        chk("fl.full0", FULL, 1'b0);
        chk("fl.win_i", RDATA_I, {2'b11, 64'b0});
        chk("fl.snap_keep", SNAP_I, exp_v);
        step("fl.snap2", 1, 0, 4'h0, 1, 1);
        chk("fl.snap_pre", SNAP_I, {2'b11, 64'b0});
`endif

        for (int c = 0; c < 400; c++) begin
            w4 = 4'($urandom_range(0, 15));
            step("rand",
                 $urandom_range(0, 49) != 0,
                 $urandom_range(0, 3) != 0,
                 w4,
                 $urandom_range(0, 3) == 0,
`ifdef IQ_WINDOW_FLUSH_EN
                 $urandom_range(0, 39) == 0
`else
                 1'b0
`endif
            );
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
